// File: rtl/weight_word_gen_pkg.sv
// Shared definitions for the fixed-weight word generator.
// Holds the default widths, the two-state encoding, and the helper that
// builds the final word of a weight-K sequence (the K ones packed at the top).
package weight_word_gen_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_KW    = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Word with the top k of 'width' bits set. k=0 gives 0 and k=width gives
  // all ones, which matches the single-word sequences at both extremes.
  function automatic logic [31:0] top_k_mask(input int width, input int k);
    logic [63:0] all_ones;
    logic [63:0] low_ones;
    all_ones = (64'd1 << width) - 64'd1;
    low_ones = (64'd1 << (width - k)) - 64'd1;
    return 32'(all_ones & ~low_ones);
  endfunction

endpackage

// File: rtl/weight_word_gen_trailing_zero_count.sv
// Trailing-zero counter: combinational priority encoder, WIDTH bits in,
// KW bits out. An all-zero input returns WIDTH.
// Ports: x (word to scan), count (index of the lowest set bit, or WIDTH).
module trailing_zero_count
  import weight_word_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int KW    = DEF_KW
) (
  input  logic [WIDTH-1:0] x,
  output logic [KW-1:0]    count
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    count = KW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) count = KW'(i);
    end
  end

endmodule

// File: rtl/weight_word_gen.sv
// Fixed-weight word generator: emits every WIDTH-bit word with exactly K ones
// in increasing order, one word per WORD_VALID/WORD_READY handshake.
// Ports: CLK/RST (async active-high), START+WEIGHT request, BUSY, WORD_VALID/
// WORD_READY handshake, WORD, LAST, WORD_IDX, ERR (weight out of range pulse).
module weight_word_gen
  import weight_word_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int KW    = DEF_KW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [KW-1:0]    WEIGHT,
  output logic             BUSY,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic [WIDTH-1:0] WORD,
  output logic             LAST,
  output logic [31:0]      WORD_IDX,
  output logic             ERR
);

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  state_t           state;
  logic [WIDTH-1:0] last_mask;
  logic [WIDTH-1:0] last_mask_d;
  logic [WIDTH-1:0] first_word;
  logic             weight_bad;
  logic [KW-1:0]    tz;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   r_ext;
  logic [WIDTH-1:0] spill;
  logic [WIDTH-1:0] next_word;

  trailing_zero_count #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_tzc (
    .x     (WORD),
    .count (tz)
  );

  // Request decode: range check, first word (K low ones) and final word.
  always_comb begin
    weight_bad  = WEIGHT > KW'(WIDTH);
    first_word  = WIDTH'((64'd1 << WEIGHT) - 64'd1);
    last_mask_d = WIDTH'(top_k_mask(WIDTH, int'(WEIGHT)));
  end

  // Gosper step: isolate the lowest set bit, add it to ripple the lowest run
  // of ones up by one place, then move the leftover ones back to the bottom.
  // The extra bit keeps the carry visible to the xor before truncation.
  always_comb begin
    x_ext     = {1'b0, WORD};
    c_ext     = x_ext & (~x_ext + ONE_EXT);
    r_ext     = x_ext + c_ext;
    spill     = WIDTH'(((r_ext ^ x_ext) >> 2) >> tz);
    next_word = spill | r_ext[WIDTH-1:0];
  end

  // Final word is recognised by value against the mask latched at START.
  assign LAST = BUSY && (WORD == last_mask);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      BUSY       <= 1'b0;
      WORD_VALID <= 1'b0;
      WORD       <= '0;
      WORD_IDX   <= '0;
      ERR        <= 1'b0;
      last_mask  <= '0;
    end else begin
      ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (weight_bad) begin
              ERR <= 1'b1;
            end else begin
              state      <= ST_RUN;
              BUSY       <= 1'b1;
              WORD_VALID <= 1'b1;
              WORD       <= first_word;
              WORD_IDX   <= '0;
              last_mask  <= last_mask_d;
            end
          end
        end
        ST_RUN: begin
          if (WORD_VALID && WORD_READY) begin
            if (LAST) begin
              // WORD and WORD_IDX keep their final values while idle.
              state      <= ST_IDLE;
              BUSY       <= 1'b0;
              WORD_VALID <= 1'b0;
            end else begin
              WORD     <= next_word;
              WORD_IDX <= WORD_IDX + 32'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_word_gen.sv
module tb_weight_word_gen;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp32_t;

  typedef struct {
    logic [7:0] word;
    logic       last;
  } exp8_t;

  logic        CLK;
  logic        RST;

  logic        start;
  logic [5:0]  weight;
  logic        busy;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word;
  logic        last;
  logic [31:0] word_idx;
  logic        err;

  logic        start8;
  logic [3:0]  weight8;
  logic        busy8;
  logic        word_valid8;
  logic        word_ready8;
  logic [7:0]  word8;
  logic        last8;
  logic [31:0] word_idx8;
  logic        err8;

  int n_checks = 0;
  int n_fails  = 0;
  int seen;

  exp32_t sb[$];
  exp8_t  sb8[$];

  weight_word_gen #(.WIDTH(32), .KW(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (start),
    .WEIGHT     (weight),
    .BUSY       (busy),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready),
    .WORD       (word),
    .LAST       (last),
    .WORD_IDX   (word_idx),
    .ERR        (err)
  );

  weight_word_gen #(.WIDTH(8), .KW(4)) dut8 (
    .CLK        (CLK),
    .RST        (RST),
    .START      (start8),
    .WEIGHT     (weight8),
    .BUSY       (busy8),
    .WORD_VALID (word_valid8),
    .WORD_READY (word_ready8),
    .WORD       (word8),
    .LAST       (last8),
    .WORD_IDX   (word_idx8),
    .ERR        (err8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Consume words from the 32-bit instance against the scoreboard.
  task automatic drain32(input string tag, input int budget, output int count);
    exp32_t e;
    bit done;
    done  = 0;
    count = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (word_valid === 1'b1 && word_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check({tag, " extra word"}, 64'(sb.size()), 64'd1);
          done = 1;
        end else begin
          e = sb.pop_front();
          check({tag, " word"}, 64'(word), 64'(e.word));
          check({tag, " idx"}, 64'(word_idx), 64'(count));
          check({tag, " last"}, 64'(last), 64'(e.last));
          if (last === 1'b1 || e.last) done = 1;
          count++;
        end
      end
      tick();
    end
    check({tag, " completed in budget"}, 64'(done), 64'd1);
  endtask

  // Consume words from the 8-bit instance; also checks ordering and weight.
  task automatic drain8(input string tag, input int budget, output int count);
    exp8_t e;
    bit done;
    logic [7:0] prev;
    done  = 0;
    count = 0;
    prev  = 8'h00;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (word_valid8 === 1'b1 && word_ready8 === 1'b1) begin
        if (sb8.size() == 0) begin
          check({tag, " extra word"}, 64'(sb8.size()), 64'd1);
          done = 1;
        end else begin
          e = sb8.pop_front();
          check({tag, " word"}, 64'(word8), 64'(e.word));
          check({tag, " popcount"}, 64'($countones(word8)), 64'd4);
          if (count > 0) check({tag, " increasing"}, 64'(word8 > prev), 64'd1);
          check({tag, " last"}, 64'(last8), 64'(e.last));
          prev = word8;
          if (last8 === 1'b1 || e.last) done = 1;
          count++;
        end
      end
      tick();
    end
    check({tag, " completed in budget"}, 64'(done), 64'd1);
  endtask

  initial begin
    RST         = 1'b1;
    start       = 1'b0;
    weight      = '0;
    word_ready  = 1'b0;
    start8      = 1'b0;
    weight8     = '0;
    word_ready8 = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst valid", 64'(word_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst last", 64'(last), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst word", 64'(word), 64'd0);
    check("rst idx", 64'(word_idx), 64'd0);
    check("rst8 valid", 64'(word_valid8), 64'd0);
    RST = 1'b0;
    tick();

    // K=2 full sequence: pairs of bits (hi, lo) in increasing order
    sb.delete();
    for (int hi = 1; hi < 32; hi++)
      for (int lo = 0; lo < hi; lo++)
        sb.push_back('{word: (32'd1 << hi) | (32'd1 << lo), last: (hi == 31 && lo == 30)});
    word_ready = 1'b1;
    start      = 1'b1;
    weight     = 6'd2;
    tick();
    start = 1'b0;
    check("k2 first valid latency", 64'(word_valid), 64'd1);
    check("k2 busy", 64'(busy), 64'd1);
    drain32("k2", 600, seen);
    check("k2 count", 64'(seen), 64'd496);
    check("k2 busy after last", 64'(busy), 64'd0);
    check("k2 valid after last", 64'(word_valid), 64'd0);
    check("k2 last after last", 64'(last), 64'd0);
    check("k2 final word held", 64'(word), 64'hC000_0000);
    check("k2 final idx held", 64'(word_idx), 64'd495);

    // K=0: single zero word
    sb.push_back('{word: 32'h0, last: 1'b1});
    start  = 1'b1;
    weight = 6'd0;
    tick();
    start = 1'b0;
    drain32("k0", 4, seen);
    check("k0 count", 64'(seen), 64'd1);
    check("k0 busy after", 64'(busy), 64'd0);

    // K=32: single all-ones word
    sb.push_back('{word: 32'hFFFF_FFFF, last: 1'b1});
    start  = 1'b1;
    weight = 6'd32;
    tick();
    start = 1'b0;
    drain32("k32", 4, seen);
    check("k32 count", 64'(seen), 64'd1);
    check("k32 valid after", 64'(word_valid), 64'd0);

    // Out-of-range weight
    start  = 1'b1;
    weight = 6'd33;
    tick();
    start = 1'b0;
    check("err pulse", 64'(err), 64'd1);
    check("err no valid", 64'(word_valid), 64'd0);
    check("err no busy", 64'(busy), 64'd0);
    tick();
    check("err one cycle", 64'(err), 64'd0);
    check("err still idle", 64'(word_valid), 64'd0);

    // K=3 with a stall on index 1, START during RUN ignored
    start  = 1'b1;
    weight = 6'd3;
    tick();
    start = 1'b0;
    check("k3 word0", 64'(word), 64'h7);
    tick();
    check("k3 word1", 64'(word), 64'hB);
    word_ready = 1'b0;
    start      = 1'b1;
    weight     = 6'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b0;
      check("k3 stall word", 64'(word), 64'hB);
      check("k3 stall idx", 64'(word_idx), 64'd1);
      check("k3 stall valid", 64'(word_valid), 64'd1);
    end
    word_ready = 1'b1;
    tick();
    check("k3 word after stall", 64'(word), 64'hD);
    check("k3 idx after stall", 64'(word_idx), 64'd2);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    tick();

    // WIDTH=8, K=4: brute-force enumeration as the reference
    sb8.delete();
    for (int v = 0; v < 256; v++)
      if ($countones(v) == 4) sb8.push_back('{word: 8'(v), last: 1'b0});
    sb8[sb8.size() - 1].last = 1'b1;
    word_ready8 = 1'b1;
    start8      = 1'b1;
    weight8     = 4'd4;
    tick();
    start8 = 1'b0;
    drain8("w8k4", 100, seen);
    check("w8k4 count", 64'(seen), 64'd70);
    check("w8k4 final word", 64'(word8), 64'hF0);
    check("w8k4 busy after", 64'(busy8), 64'd0);

    // K=16, reset after index 5
    start  = 1'b1;
    weight = 6'd16;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("k16 idx5", 64'(word_idx), 64'd5);
    check("k16 word5", 64'(word), 64'h1_F7FF);
    RST = 1'b1;
    #1;
    check("async rst valid", 64'(word_valid), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst word", 64'(word), 64'd0);
    #1;
    RST = 1'b0;
    tick();
    start  = 1'b1;
    weight = 6'd16;
    tick();
    start = 1'b0;
    check("k16 restart word", 64'(word), 64'h0000_FFFF);
    check("k16 restart idx", 64'(word_idx), 64'd0);
    tick();
    check("k16 restart word1", 64'(word), 64'h1_7FFF);
    check("k16 restart idx1", 64'(word_idx), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
